// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART constants: FSM state encoding and baud divisor.
//  Revision : 1.0  initial release
// ============================================================================

package uart_pkg;

   localparam int STATE_W = 3;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;

   // Integer-truncated clock cycles per line bit.
   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Generic two-flop synchronizer for asynchronous inputs.
//  Revision : 1.0  initial release
// ============================================================================

module sync_2ff #(
   parameter int   WIDTH     = 1,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= {WIDTH{RESET_VAL}};
         r_sync <= {WIDTH{RESET_VAL}};
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver with one-byte buffer and valid/ready output.
//  Revision : 1.0  initial release
// ============================================================================

module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 frame_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
   localparam int BIT_W        = $clog2(DATA_BITS + 1);

   localparam logic [BAUD_W-1:0] C_HALF_LAST = BAUD_W'(HALF_BIT - 1);
   localparam logic [BAUD_W-1:0] C_BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  C_LAST_DATA = BIT_W'(DATA_BITS - 1);

   logic                  w_rx_s;
   logic                  w_bit_tick;

   logic [STATE_W-1:0]    r_state;
   logic [BAUD_W-1:0]     r_baud_cnt;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic [DATA_BITS-1:0]  r_shift;
   logic                  r_load_pend;
   logic                  r_frame_err;

   logic [DATA_BITS-1:0]  r_data;
   logic                  r_valid;
   logic                  r_overrun;

   // Idle-high line: preset the synchronizer to 1 so reset never fakes a start.
   sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_sync_rx (
      .clk (clk_i),
      .rst (reset_i),
      .i_d (rx_i),
      .o_q (w_rx_s)
   );

   assign w_bit_tick = (r_baud_cnt == C_BIT_LAST);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state     <= S_IDLE;
         r_baud_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_load_pend <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_load_pend <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_rx_s) begin
                  r_state    <= S_START;
                  r_baud_cnt <= '0;
               end
            end
            S_START: begin
               // Confirm the start bit at its midpoint; this also sets the
               // mid-bit phase used for every later sample.
               if (r_baud_cnt == C_HALF_LAST) begin
                  r_baud_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_state    <= w_rx_s ? S_IDLE : S_DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
               end
            end
            S_DATA: begin
               if (w_bit_tick) begin
                  r_baud_cnt <= '0;
                  r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                  r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
                  if (r_bit_cnt == C_LAST_DATA) begin
                     r_state <= S_STOP;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
               end
            end
            S_STOP: begin
               if (w_bit_tick) begin
                  r_baud_cnt <= '0;
                  if (w_rx_s) begin
                     r_load_pend <= 1'b1;
                     r_state     <= S_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_WAIT_IDLE;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
               end
            end
            S_WAIT_IDLE: begin
               if (w_rx_s) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Output buffer. The shift register is untouched while r_load_pend is
   // high because the FSM is back in IDLE and cannot reach DATA yet.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (r_valid && ready_i) begin
            r_valid <= 1'b0;
         end
         if (r_load_pend) begin
            if (!r_valid || ready_i) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end
      end
   end

   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign frame_err_o = r_frame_err;
   assign overrun_o   = r_overrun;
   assign busy_o      = (r_state != S_IDLE);

endmodule

`default_nettype wire
